hd44780_ctrl: RTL and testbench

- Sequencer that powers up an HD44780 character LCD in 8-bit, write-only mode.
- Copies a two-line page from the combinational character ROM, hd44780_data, to the display's DDRAM.
- Drives the ROM address and the LCD pins, and enforces every LCD timing constraint with cycle counters.
- Sits between the character ROM and the board LCD header; a refresh pulse re-copies the page without re-initialising.

---
 rtl/hd44780_pkg.sv | 45 ++++
 rtl/hd44780_bus_cycle.sv | 110 +++++++++++
 rtl/hd44780_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hd44780_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// hd44780_pkg: constants, state encodings and init table shared by the
// HD44780 controller and its bus-cycle timer.
package hd44780_pkg;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    // Init table has six entries; step 4 is the clear.
    localparam logic [5:0] INIT_LAST  = 6'd5;
    localparam logic [5:0] INIT_CLEAR = 6'd4;

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_LINE,
        ST_CHARS,
        ST_IDLE
    } ctrl_state_e;

    typedef enum logic [2:0] {
        BC_IDLE,
        BC_SETUP,
        BC_EHI,
        BC_HOLD,
        BC_WAIT
    } bus_state_e;

    function automatic logic [7:0] init_cmd(input logic [2:0] step);
        logic [7:0] cmd;
        case (step)
            3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_8B2L;
            3'd3:             cmd = CMD_DISP_ON;
            3'd4:             cmd = CMD_CLEAR;
            default:          cmd = CMD_ENTRY_INC;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/hd44780_bus_cycle.sv
// hd44780_bus_cycle: one LCD write cycle (SETUP, E high, HOLD, wait).
// Ports: clk/rst; go+rs/db/long_wait request; busy/done status;
// registered lcd_rs/lcd_e/lcd_db pins.
module hd44780_bus_cycle
    import hd44780_pkg::*;
#(
    parameter int T_EPW_CYC   = 6,
    parameter int T_EXEC_CYC  = 480,
    parameter int T_CLEAR_CYC = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] db,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam logic [19:0] EPW_LAST  = 20'(T_EPW_CYC - 1);
    localparam logic [19:0] EXEC_LAST = 20'(T_EXEC_CYC - 1);
    localparam logic [19:0] CLR_LAST  = 20'(T_CLEAR_CYC - 1);

    bus_state_e  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] wait_last;
    logic        rs_q, rs_d;
    logic [7:0]  db_q, db_d;
    logic        long_q, long_d;
    logic        e_q, e_d;
    logic        done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs_d      = rs_q;
        db_d      = db_q;
        long_d    = long_q;
        done_d    = 1'b0;
        wait_last = long_q ? CLR_LAST : EXEC_LAST;
        unique case (state_q)
            BC_IDLE: begin
                if (go) begin
                    state_d = BC_SETUP;
                    rs_d    = rs;
                    db_d    = db;
                    long_d  = long_wait;
                end
            end
            BC_SETUP: begin
                state_d = BC_EHI;
                cnt_d   = '0;
            end
            BC_EHI: begin
                if (cnt_q == EPW_LAST) begin
                    state_d = BC_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            BC_HOLD: begin
                state_d = BC_WAIT;
                cnt_d   = '0;
            end
            BC_WAIT: begin
                if (cnt_q == wait_last) begin
                    state_d = BC_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: state_d = BC_IDLE;
        endcase
        // E is registered from the next state so it lines up with EHI.
        e_d = (state_d == BC_EHI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BC_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            long_q  <= 1'b0;
            e_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            long_q  <= long_d;
            e_q     <= e_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q != BC_IDLE);
    assign done   = done_q;
    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_db = db_q;

endmodule

// File: rtl/hd44780_ctrl.sv
// hd44780_ctrl: powers up an HD44780 in 8-bit mode and copies a two-line
// page from the character ROM. Ports: clk/rst, refresh, rom_addr/rom_data,
// lcd_rs/lcd_rw/lcd_e/lcd_db pins, ready (page written, idle).
module hd44780_ctrl
    import hd44780_pkg::*;
#(
    parameter int T_POWER_CYC = 600000,
    parameter int T_EPW_CYC   = 6,
    parameter int T_EXEC_CYC  = 480,
    parameter int T_CLEAR_CYC = 19200,
    parameter int COLS        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       ready
);

    localparam logic [19:0] PWR_LAST = 20'(T_POWER_CYC - 1);
    localparam logic [5:0]  COL_LAST = 6'(COLS - 1);

    ctrl_state_e state_q, state_d;
    logic [19:0] pwr_q, pwr_d;
    // Init step in INIT, column in CHARS.
    logic [5:0]  idx_q, idx_d;
    logic        line_q, line_d;
    logic        issued_q, issued_d;
    logic        go_q, go_d;
    logic        rs_q, rs_d;
    logic        use_rom_q, use_rom_d;
    logic        long_q, long_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [6:0]  addr_q, addr_d;
    logic        ready_q, ready_d;

    logic [6:0]  base;
    logic [7:0]  bc_db;
    logic        bc_busy;
    logic        bc_done;

    assign base  = line_q ? LINE1_BASE : LINE0_BASE;
    // ROM data goes straight to the latch; rom_addr settled a cycle earlier.
    assign bc_db = use_rom_q ? rom_data : cmd_q;

    always_comb begin
        state_d   = state_q;
        pwr_d     = pwr_q;
        idx_d     = idx_q;
        line_d    = line_q;
        issued_d  = issued_q;
        go_d      = 1'b0;
        rs_d      = rs_q;
        use_rom_d = use_rom_q;
        long_d    = long_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        ready_d   = ready_q;
        unique case (state_q)
            ST_POWER_WAIT: begin
                if (pwr_q == PWR_LAST) begin
                    state_d  = ST_INIT;
                    idx_d    = '0;
                    issued_d = 1'b0;
                end else begin
                    pwr_d = pwr_q + 20'd1;
                end
            end
            ST_INIT: begin
                if (!issued_q && !bc_busy) begin
                    go_d      = 1'b1;
                    issued_d  = 1'b1;
                    rs_d      = 1'b0;
                    use_rom_d = 1'b0;
                    cmd_d     = init_cmd(idx_q[2:0]);
                    long_d    = (idx_q == INIT_CLEAR);
                end else if (issued_q && bc_done) begin
                    issued_d = 1'b0;
                    if (idx_q == INIT_LAST) begin
                        state_d = ST_LINE;
                        line_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_LINE: begin
                if (!issued_q && !bc_busy) begin
                    go_d      = 1'b1;
                    issued_d  = 1'b1;
                    rs_d      = 1'b0;
                    use_rom_d = 1'b0;
                    long_d    = 1'b0;
                    cmd_d     = CMD_SET_DDRAM | {1'b0, base};
                end else if (issued_q && bc_done) begin
                    issued_d = 1'b0;
                    state_d  = ST_CHARS;
                    idx_d    = '0;
                end
            end
            ST_CHARS: begin
                if (!issued_q && !bc_busy) begin
                    go_d      = 1'b1;
                    issued_d  = 1'b1;
                    rs_d      = 1'b1;
                    use_rom_d = 1'b1;
                    long_d    = 1'b0;
                    addr_d    = base + {1'b0, idx_q};
                end else if (issued_q && bc_done) begin
                    issued_d = 1'b0;
                    if (idx_q == COL_LAST) begin
                        idx_d = '0;
                        if (line_q) begin
                            state_d = ST_IDLE;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_LINE;
                            line_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh) begin
                    state_d  = ST_LINE;
                    ready_d  = 1'b0;
                    line_d   = 1'b0;
                    idx_d    = '0;
                    issued_d = 1'b0;
                end
            end
            default: state_d = ST_POWER_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_POWER_WAIT;
            pwr_q     <= '0;
            idx_q     <= '0;
            line_q    <= 1'b0;
            issued_q  <= 1'b0;
            go_q      <= 1'b0;
            rs_q      <= 1'b0;
            use_rom_q <= 1'b0;
            long_q    <= 1'b0;
            cmd_q     <= 8'h00;
            addr_q    <= 7'h00;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwr_q     <= pwr_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
            issued_q  <= issued_d;
            go_q      <= go_d;
            rs_q      <= rs_d;
            use_rom_q <= use_rom_d;
            long_q    <= long_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ready_q   <= ready_d;
        end
    end

    hd44780_bus_cycle #(
        .T_EPW_CYC  (T_EPW_CYC),
        .T_EXEC_CYC (T_EXEC_CYC),
        .T_CLEAR_CYC(T_CLEAR_CYC)
    ) u_bus (
        .clk      (clk),
        .rst      (rst),
        .go       (go_q),
        .rs       (rs_q),
        .db       (bc_db),
        .long_wait(long_q),
        .busy     (bc_busy),
        .done     (bc_done),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_db   (lcd_db)
    );

    assign lcd_rw   = 1'b0;
    assign rom_addr = addr_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb_hd44780_ctrl: directed bench for hd44780_ctrl with a character ROM
// model and an E-strobe recorder; one task per scenario.
module tb_hd44780_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refresh = 1'b0;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic       ready;

    always #5 clk = ~clk;

    hd44780_ctrl #(
        .T_POWER_CYC(100),
        .T_EPW_CYC  (2),
        .T_EXEC_CYC (5),
        .T_CLEAR_CYC(20),
        .COLS       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .refresh (refresh),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_db  (lcd_db),
        .ready   (ready)
    );

    string      l0 = "Hello, world.   ";
    string      l1 = "PrjIcestorm FTW!";
    logic [7:0] rom_mem [0:127];
    logic [7:0] init_exp [6] = '{8'h38, 8'h38, 8'h38,
                                 8'h0C, 8'h01, 8'h06};

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = 8'h3F;
        for (int i = 0; i < 16; i++) begin
            rom_mem[i]      = l0[i];
            rom_mem[64 + i] = l1[i];
        end
    end

    assign rom_data = rom_mem[rom_addr];

    typedef struct {
        logic       rs;
        logic [7:0] db;
        logic [6:0] addr;
        int         width;
        bit         stable;
        int         gap;
        int         cyc;
    } strobe_t;

    strobe_t    strobes[$];
    strobe_t    cur;
    bit         in_pulse = 1'b0;
    int         low_run = 0;
    int         rw_bad = 0;
    int         cyc = 0;
    logic       prev_rs = 1'b0;
    logic [7:0] prev_db = 8'h00;

    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Records every E pulse: its bus value, width, setup/hold stability
    // and the number of E-low cycles in front of it.
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
        end else begin
            if (lcd_rw !== 1'b0) rw_bad++;
            if (lcd_e === 1'b1 && !in_pulse) begin
                cur.rs     = lcd_rs;
                cur.db     = lcd_db;
                cur.addr   = rom_addr;
                cur.width  = 1;
                cur.stable = (lcd_rs === prev_rs) && (lcd_db === prev_db);
                cur.gap    = low_run;
                cur.cyc    = cyc;
                in_pulse   = 1'b1;
            end else if (lcd_e === 1'b1) begin
                cur.width++;
                if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 1'b0;
            end else if (in_pulse) begin
                if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 1'b0;
                strobes.push_back(cur);
                in_pulse = 1'b0;
            end
        end
        low_run = (lcd_e === 1'b1) ? 0 : low_run + 1;
        prev_rs = lcd_rs;
        prev_db = lcd_db;
    end

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (strobes.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        refresh = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (lcd_e !== 1'b0) $display("FAIL reset_e: got %b want 0", lcd_e);
        else n_pass++;
        n_checks++;
        if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", lcd_rs);
        else n_pass++;
        n_checks++;
        if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", lcd_rw);
        else n_pass++;
        n_checks++;
        if (lcd_db !== 8'h00) $display("FAIL reset_db: got %h want 00", lcd_db);
        else n_pass++;
        n_checks++;
        if (rom_addr !== 7'h00) $display("FAIL reset_addr: got %h want 00", rom_addr);
        else n_pass++;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready);
        else n_pass++;
        rst = 1'b0;
        strobes.delete();
        rw_bad = 0;
    endtask

    task automatic check_init_seq(input string tag);
        bit ok;
        wait_strobes(6, 2000, ok);
        n_checks++;
        if (!ok) $display("FAIL %s_timeout: got %0d strobes want 6", tag, strobes.size());
        else n_pass++;
        if (ok) begin
            n_checks++;
            if (strobes[0].cyc < 100)
                $display("FAIL %s_power_wait: first E at cycle %0d want >= 100",
                         tag, strobes[0].cyc);
            else n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (strobes[i].rs !== 1'b0 || strobes[i].db !== init_exp[i])
                    $display("FAIL %s_cmd[%0d]: got rs=%b db=%h want rs=0 db=%h",
                             tag, i, strobes[i].rs, strobes[i].db, init_exp[i]);
                else n_pass++;
            end
            n_checks++;
            if (strobes[5].gap < 20)
                $display("FAIL %s_clear_gap: got %0d low cycles want >= 20",
                         tag, strobes[5].gap);
            else n_pass++;
        end
    endtask

    task automatic test_init();
        check_init_seq("init");
    endtask

    task automatic test_page();
        bit ok;
        wait_ready(4000, ok);
        n_checks++;
        if (!ok) $display("FAIL page_ready: got 0 want 1 within budget");
        else n_pass++;
        n_checks++;
        if (strobes.size() != 40)
            $display("FAIL page_count: got %0d want 40", strobes.size());
        else n_pass++;
        if (strobes.size() == 40) begin
            for (int i = 6; i < 40; i++) begin
                logic       er;
                logic [7:0] ed;
                logic [6:0] ea;
                bit         is_data;
                is_data = 1'b1;
                ea = 7'h00;
                if (i == 6) begin
                    er = 1'b0; ed = 8'h80; is_data = 1'b0;
                end else if (i == 23) begin
                    er = 1'b0; ed = 8'hC0; is_data = 1'b0;
                end else if (i < 23) begin
                    er = 1'b1; ed = l0[i - 7]; ea = 7'(i - 7);
                end else begin
                    er = 1'b1; ed = l1[i - 24]; ea = 7'h40 + 7'(i - 24);
                end
                n_checks++;
                if (strobes[i].rs !== er || strobes[i].db !== ed)
                    $display("FAIL page_strobe[%0d]: got rs=%b db=%h want rs=%b db=%h",
                             i, strobes[i].rs, strobes[i].db, er, ed);
                else n_pass++;
                if (is_data) begin
                    n_checks++;
                    if (strobes[i].addr !== ea)
                        $display("FAIL page_addr[%0d]: got %h want %h",
                                 i, strobes[i].addr, ea);
                    else n_pass++;
                end
            end
        end
        foreach (strobes[i]) begin
            n_checks++;
            if (strobes[i].width != 2 || !strobes[i].stable)
                $display("FAIL page_timing[%0d]: got width=%0d stable=%b want 2/1",
                         i, strobes[i].width, strobes[i].stable);
            else n_pass++;
        end
        n_checks++;
        if (rw_bad != 0) $display("FAIL page_rw: got %0d high cycles want 0", rw_bad);
        else n_pass++;
    endtask

    task automatic check_refresh_page(input string tag);
        bit ok;
        int n38;
        wait_ready(4000, ok);
        n_checks++;
        if (!ok) $display("FAIL %s_ready: got 0 want 1 within budget", tag);
        else n_pass++;
        n_checks++;
        if (strobes.size() != 34)
            $display("FAIL %s_count: got %0d want 34", tag, strobes.size());
        else n_pass++;
        if (strobes.size() == 34) begin
            n_checks++;
            if (strobes[0].rs !== 1'b0 || strobes[0].db !== 8'h80)
                $display("FAIL %s_first: got rs=%b db=%h want rs=0 db=80",
                         tag, strobes[0].rs, strobes[0].db);
            else n_pass++;
            n_checks++;
            if (strobes[17].db !== 8'hC0)
                $display("FAIL %s_line1: got %h want c0", tag, strobes[17].db);
            else n_pass++;
            n38 = 0;
            foreach (strobes[i])
                if (strobes[i].rs === 1'b0 && strobes[i].db === 8'h38) n38++;
            n_checks++;
            if (n38 != 0) $display("FAIL %s_no_init: got %0d x 38 want 0", tag, n38);
            else n_pass++;
        end
    endtask

    task automatic test_refresh();
        strobes.delete();
        pulse_refresh();
        n_checks++;
        if (ready !== 1'b0) $display("FAIL refresh_ready_fall: got %b want 0", ready);
        else n_pass++;
        check_refresh_page("refresh");
    endtask

    task automatic test_refresh_dropped();
        bit ok;
        strobes.delete();
        pulse_refresh();
        wait_strobes(5, 1000, ok);
        pulse_refresh();
        check_refresh_page("dropped");
        repeat (200) @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || strobes.size() != 34)
            $display("FAIL dropped_queued: got ready=%b strobes=%0d want 1/34",
                     ready, strobes.size());
        else n_pass++;
    endtask

    task automatic test_refresh_in_init();
        bit ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        refresh = 1'b1;
        rst = 1'b0;
        strobes.delete();
        check_init_seq("held");
        refresh = 1'b0;
        wait_ready(4000, ok);
        n_checks++;
        if (!ok || strobes.size() != 40)
            $display("FAIL held_count: got ready=%b strobes=%0d want 1/40",
                     ready, strobes.size());
        else n_pass++;
        // First ready cycle: a refresh here must be taken.
        strobes.delete();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL first_ready_refresh: got %b want 0", ready);
        else n_pass++;
        check_refresh_page("first_ready");
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hi;
        strobes.delete();
        pulse_refresh();
        wait_strobes(10, 1000, ok);
        hi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lcd_e === 1'b1) begin
                hi = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hi) $display("FAIL midrst_find_e: got 0 want E high in CHARS");
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (lcd_e !== 1'b0 || ready !== 1'b0)
            $display("FAIL midrst_abort: got e=%b ready=%b want 0/0", lcd_e, ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strobes.delete();
        check_init_seq("midrst");
        wait_ready(4000, ok);
        n_checks++;
        if (!ok || strobes.size() != 40)
            $display("FAIL midrst_count: got ready=%b strobes=%0d want 1/40",
                     ready, strobes.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_page();
        test_refresh();
        test_refresh_dropped();
        test_refresh_in_init();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
